uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Transmit-side counterpart of uart_router: N response sources (digit_reader 0xCC,
//   scores_reader 0xCD, future status reply) share the one uart_tx.
//   Grants one source per packet, round-robin. Forwards its bytes through the
//   uart_tx send/busy handshake. Holds the grant until that source's last byte is sent.
//   Replaces the combinational OR mux in top.
// PARAMETERS
//   N_SRC         3        number of response sources (1..8)
//   WD_CYCLES     1000000  idle cycles allowed while granted before a source is dropped (10 ms @100 MHz)
//   BUSY_WAIT     4        max cycles after tx_send for tx_busy to rise before byte assumed lost
// PORTS
//   clk           in   1        system clock, 100 MHz
//   rst           in   1        synchronous, active-high reset
//   src_req       in   N_SRC    source i wants to send a packet (level, held until grant)
//   src_data      in   8*N_SRC  byte of source i at [8i+7:8i]
//   src_valid     in   N_SRC    src_data[i] valid this cycle
//   src_last      in   N_SRC    current byte is the final byte of the packet
//   src_grant     out  N_SRC    one-hot; source i owns the TX channel
//   src_ack       out  N_SRC    1-cycle pulse: byte of source i accepted; source advances
//   tx_data       out  8        to uart_tx.data, stable from send until busy falls
//   tx_send       out  1        1-cycle pulse to uart_tx.send
//   tx_busy       in   1        from uart_tx
//   active        out  1        a grant is held
//   wd_err        out  1        1-cycle pulse: granted source timed out, grant dropped
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, rr pointer = 0 (source 0 highest priority).
//   FSM:
//   - IDLE: if any src_req, pick the first requester at or after rr_ptr, wrapping modulo N_SRC.
//     Register src_grant next cycle (req->grant latency 1). Go to WAIT_VALID.
//   - WAIT_VALID: wait for src_valid[g].
//     - On valid: latch src_data[g] into tx_data and src_last[g] into last_q, pulse src_ack[g].
//       Go to SEND.
//     - The watchdog counter runs here; it is cleared on every accepted byte.
//     - At WD_CYCLES: pulse wd_err, clear grant, set rr_ptr=g+1, go to IDLE.
//   - SEND: tx_send=1 for exactly one cycle. Go to WAIT_HI.
//   - WAIT_HI: wait for tx_busy=1. If not seen within BUSY_WAIT cycles, treat the byte as sent.
//     Then go to WAIT_LO.
//   - WAIT_LO: wait for tx_busy=0.
//     - If last_q: clear grant, set rr_ptr=g+1 (wraps), go to IDLE.
//     - Else: go to WAIT_VALID.
//   Handshake rules:
//   - src_ack only for the granted source; data/valid/last of ungranted sources are ignored.
//   - A source must not drop src_req while granted. If it does, the arbiter ignores the drop;
//     the packet ends only on src_last or the watchdog.
//   - tx_data held constant from SEND until next accepted byte; never changes while tx_busy=1.
//   - Never issue tx_send while tx_busy=1, even from IDLE (wait for busy low before SEND).
//   Simultaneous events:
//   - Requests arriving during a packet are queued by level and served after release.
//   - Release and a new arbitration never share a cycle; IDLE always costs >=1 cycle.
//   Boundaries:
//   - Single-byte packet (valid & last in the same cycle) is legal.
//   - N_SRC=1 degenerates to a pass-through with packet framing.
//   - rr_ptr wraps N_SRC-1 -> 0.
//   Reset mid-packet: grant and tx_send drop on the next edge. A byte already inside uart_tx
//   completes on the line; sources must restart their packet after reset.
//   Widths:
//   - Watchdog counter = $clog2(WD_CYCLES+1) bits, saturating.
//   - rr_ptr = $clog2(N_SRC) bits (min 1).
// STRUCTURE
//   Shared package uart_pkg: state encoding (IDLE, WAIT_VALID, SEND, WAIT_HI, WAIT_LO),
//   source IDs SRC_DIGIT=0, SRC_SCORES=1, SRC_STATUS=2, command bytes 0xCC/0xCD.
//   One sub-module: rr_pick (combinational round-robin priority encoder: req, ptr -> one-hot).
//   Counters and FSM stay in this module.
//   top: u_uart_tx_arbiter sits between the readers and u_digit_tx.
// TESTING
//   - Src0 sends 1 byte 0x07 with last; uart_tx model (busy 1 cycle after send, 868 cycles per byte)
//     -> one tx_send, tx_data=0x07, grant released, active=0.
//   - Src1 sends 40 score bytes 0x00..0x27, last on byte 40 -> exactly 40 tx_send pulses in order,
//     none while busy=1, 40 src_ack.
//   - Src0 and src1 request in the same cycle, both 2-byte packets, then both again
//     -> grant order 0,1,1... no: 0,1 then 0 rotates: second round grants 0 first only if rr_ptr=0,
//     so expect packet order 0,1,0,1; no interleaved bytes.
//   - Src2 granted, never asserts valid; WD_CYCLES=100 in bench -> wd_err pulse at cycle 101,
//     grant cleared, pending src0 served next.
//   - Rst asserted while byte 3 of a 40-byte packet is in WAIT_LO
//     -> next edge: src_grant=0, tx_send=0, active=0, rr_ptr=0.
//   - uart_tx model never raises busy -> byte treated as sent after BUSY_WAIT=4 cycles,
//     next byte proceeds, no hang.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: TX arbiter state encoding,
// response source IDs and command bytes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    SEND,
    WAIT_HI,
    WAIT_LO
  } arb_state_t;

  localparam int SRC_DIGIT  = 0;
  localparam int SRC_SCORES = 1;
  localparam int SRC_STATUS = 2;

  localparam logic [7:0] CMD_DIGIT  = 8'hCC;
  localparam logic [7:0] CMD_SCORES = 8'hCD;

  // pointer width for n sources, never below one bit
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first requester at or after ptr,
// wrapping modulo N, returned one-hot.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    int j;
    gnt = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      for (int i = 0; i < N; i++) begin
        if (i == j && req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx among N response
// sources; holds the grant until the packet's last byte is on the line.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int WD_CYCLES = 1000000,
  parameter int BUSY_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_grant,
  output logic [N_SRC-1:0]   src_ack,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy,
  output logic               active,
  output logic               wd_err
);

  localparam int PW = ptr_w(N_SRC);
  localparam int WW = $clog2(WD_CYCLES + 1);
  localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  arb_state_t       state, state_nxt;
  logic [PW-1:0]    rr_ptr, g_idx, pick_idx, g_nxt;
  logic [N_SRC-1:0] pick;
  logic [WW-1:0]    wd_cnt;
  logic [BW-1:0]    bw_cnt;
  logic             last_q;
  logic             cur_valid, cur_last;
  logic [7:0]       cur_data;
  logic             wd_hit, accept, rel;

  rr_pick #(
    .N  (N_SRC),
    .PW (PW)
  ) u_rr_pick (
    .req (src_req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    pick_idx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (g_idx == PW'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[8*i +: 8];
      end
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign wd_hit = (state == WAIT_VALID) && !cur_valid
               && (wd_cnt == WW'(WD_CYCLES));
  assign accept = (state == WAIT_VALID) && cur_valid;
  assign rel    = wd_hit
               || ((state == WAIT_LO) && !tx_busy && last_q);
  assign g_nxt  = (g_idx == PW'(N_SRC - 1)) ? '0 : g_idx + 1'b1;
  assign active = |src_grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (|src_req) state_nxt = WAIT_VALID;
      WAIT_VALID:
        if (cur_valid)   state_nxt = SEND;
        else if (wd_hit) state_nxt = IDLE;
      SEND:
        if (!tx_busy) state_nxt = WAIT_HI;
      // a byte whose busy never shows up is taken as sent
      WAIT_HI:
        if (tx_busy || bw_cnt == BW'(BUSY_WAIT - 1))
          state_nxt = WAIT_LO;
      WAIT_LO:
        if (!tx_busy) state_nxt = last_q ? IDLE : WAIT_VALID;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_ack = '0;
    tx_send = 1'b0;
    wd_err  = 1'b0;
    unique case (state)
      WAIT_VALID: begin
        if (cur_valid) src_ack = src_grant;
        wd_err = wd_hit;
      end
      SEND:    tx_send = !tx_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_grant <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      tx_data   <= '0;
      last_q    <= 1'b0;
      wd_cnt    <= '0;
      bw_cnt    <= '0;
    end else begin
      if (state == IDLE && |src_req) begin
        src_grant <= pick;
        g_idx     <= pick_idx;
      end
      if (rel) begin
        src_grant <= '0;
        rr_ptr    <= g_nxt;
      end
      if (accept) begin
        tx_data <= cur_data;
        last_q  <= cur_last;
      end
      if (state != WAIT_VALID || cur_valid)
        wd_cnt <= '0;
      else if (wd_cnt != WW'(WD_CYCLES))
        wd_cnt <= wd_cnt + 1'b1;
      if (state == WAIT_HI) bw_cnt <= bw_cnt + 1'b1;
      else                  bw_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model,
// randomized source timing, uart_tx busy model and reset mid-packet.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 3;
  localparam int WD = 100;
  localparam int BWAIT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   src_req, src_valid, src_last;
  logic [N-1:0]   src_grant, src_ack;
  logic [8*N-1:0] src_data;
  logic [7:0]     tx_data;
  logic           tx_send, tx_busy, active, wd_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_SRC     (N),
    .WD_CYCLES (WD),
    .BUSY_WAIT (BWAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_grant (src_grant),
    .src_ack   (src_ack),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .active    (active),
    .wd_err    (wd_err)
  );

  typedef struct {
    bit         wd;
    int         src;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [8:0] sq[N][$];
  logic [8:0] mq[N][$];
  bit         mute[N];
  int         m_ptr = 0;
  int         byte_cyc = 868;
  bit         no_busy = 1'b0;
  int         n_send = 0, n_ack = 0, n_wd = 0, cyc = 0;
  int         n_cmp = 0, n_err = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++)
      if (sq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic load_pkt(input int s, input int len, input bit seq,
                          input logic [7:0] first);
    logic [7:0] d;
    logic [8:0] w;
    for (int b = 0; b < len; b++) begin
      d = seq ? first + 8'(b) : 8'($urandom);
      w = {b == len - 1, d};
      sq[s].push_back(w);
      mq[s].push_back(w);
    end
  endtask

  // Packet-level round robin: every queued packet is pending at once.
  function automatic void plan();
    int s;
    int c;
    logic [8:0] w;
    ev_t e;
    forever begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (s < 0 && mq[c].size() > 0) s = c;
      end
      if (s < 0) break;
      do begin
        w = mq[s].pop_front();
        if (!mute[s]) begin
          e.wd = 1'b0; e.src = s; e.data = w[7:0];
          exp_q.push_back(e);
        end
      end while (!w[8] && mq[s].size() > 0);
      if (mute[s]) begin
        e.wd = 1'b1; e.src = s; e.data = 8'h00;
        exp_q.push_back(e);
      end
      m_ptr = (s + 1) % N;
    end
  endfunction

  task automatic sync_in();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget, input string nm);
    int t;
    t = 0;
    while (t < budget && !(exp_q.size() == 0 && !active
           && !tx_busy && all_empty())) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, 32'(t >= budget), 0);
  endtask

  // source models
  initial begin
    logic [N-1:0] ack_s, gnt_s;
    logic         wd_s;
    logic [8:0]   w;
    src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
    forever begin
      @(negedge clk);
      ack_s = src_ack; gnt_s = src_grant; wd_s = wd_err;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack_s[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (wd_s && gnt_s[i]) begin
          while (sq[i].size() > 0) begin
            w = sq[i].pop_front();
            if (w[8]) break;
          end
        end
        src_req[i] = sq[i].size() > 0;
        if (src_grant[i] && sq[i].size() > 0 && !mute[i]) begin
          src_valid[i] = $urandom_range(0, 3) != 0;
          src_data[8*i +: 8] = sq[i][0][7:0];
          src_last[i] = sq[i][0][8];
        end else if (src_grant[i]) begin
          src_valid[i] = 1'b0;
          src_data[8*i +: 8] = 8'($urandom);
          src_last[i] = 1'($urandom);
        end else begin
          src_valid[i] = 1'($urandom);
          src_data[8*i +: 8] = 8'($urandom);
          src_last[i] = 1'($urandom);
        end
      end
    end
  end

  // uart_tx model: busy one cycle after send, byte_cyc cycles long
  initial begin
    logic s;
    int   cnt;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      s = tx_send;
      @(posedge clk);
      #1;
      if (s && !no_busy) begin
        tx_busy = 1'b1;
        cnt = byte_cyc;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_busy = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [N-1:0] prev_g;
    logic [7:0]   held;
    int           g_start;
    bit           chg, stab_ok, prev_busy;
    ev_t          e;
    prev_g = '0; held = '0; g_start = 0;
    chg = 1'b0; stab_ok = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (src_grant != '0 && prev_g == '0) g_start = cyc;
      prev_g = src_grant;
      if (tx_send) begin
        n_send++;
        chk("send_while_busy", 32'(tx_busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_send", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind_send", 32'(e.wd), 0);
          chk("send_src", 32'(src_grant), 32'(1) << e.src);
          chk("send_data", 32'(tx_data), 32'(e.data));
        end
        held = tx_data; chg = 1'b0; stab_ok = 1'b1;
      end
      if (wd_err) begin
        n_wd++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wd", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind_wd", 32'(e.wd), 1);
          chk("wd_src", 32'(src_grant), 32'(1) << e.src);
          chk("wd_latency", 32'(cyc - g_start), WD);
        end
      end
      if (src_ack != '0) begin
        n_ack++;
        chk("ack_granted", 32'(src_ack), 32'(src_grant));
      end
      if (rst) stab_ok = 1'b0;
      if (stab_ok && tx_busy && tx_data !== held) chg = 1'b1;
      if (stab_ok && prev_busy && !tx_busy) begin
        chk("data_stable", 32'(chg), 0);
        chg = 1'b0;
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    int bs, ba, bw, t;
    for (int i = 0; i < N; i++) mute[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(src_grant), 0);
    chk("rst_ack", 32'(src_ack), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_wd", 32'(wd_err), 0);
    sync_in();
    rst = 1'b0;

    byte_cyc = 868;
    sync_in();
    bs = n_send;
    load_pkt(0, 1, 1'b1, 8'h07);
    plan();
    drain(5000, "single");
    chk("single_sends", 32'(n_send - bs), 1);
    chk("single_active", 32'(active), 0);
    chk("single_grant", 32'(src_grant), 0);

    sync_in();
    bs = n_send; ba = n_ack;
    load_pkt(1, 40, 1'b1, 8'h00);
    plan();
    drain(60000, "scores");
    chk("scores_sends", 32'(n_send - bs), 40);
    chk("scores_acks", 32'(n_ack - ba), 40);

    byte_cyc = 20;
    sync_in();
    bs = n_send;
    load_pkt(0, 2, 1'b0, 8'h00);
    load_pkt(0, 2, 1'b0, 8'h00);
    load_pkt(1, 2, 1'b0, 8'h00);
    load_pkt(1, 2, 1'b0, 8'h00);
    plan();
    drain(5000, "rr_pair");
    chk("rr_pair_sends", 32'(n_send - bs), 8);

    sync_in();
    bw = n_wd;
    mute[2] = 1'b1;
    load_pkt(2, 3, 1'b0, 8'h00);
    load_pkt(0, 2, 1'b0, 8'h00);
    plan();
    drain(5000, "watchdog");
    mute[2] = 1'b0;
    chk("watchdog_pulses", 32'(n_wd - bw), 1);

    no_busy = 1'b1;
    sync_in();
    bs = n_send;
    load_pkt(1, 3, 1'b0, 8'h00);
    plan();
    drain(2000, "no_busy");
    no_busy = 1'b0;
    chk("no_busy_sends", 32'(n_send - bs), 3);

    repeat (6) begin
      byte_cyc = $urandom_range(1, 30);
      sync_in();
      for (int s = 0; s < N; s++) begin
        for (int p = $urandom_range(0, 2); p > 0; p--)
          load_pkt(s, $urandom_range(1, 6), 1'b0, 8'h00);
      end
      plan();
      drain(20000, "random");
    end

    // leave rr_ptr at 1 so a missing pointer reset would show
    byte_cyc = 20;
    sync_in();
    load_pkt(0, 1, 1'b0, 8'h00);
    plan();
    drain(2000, "pre_reset");

    byte_cyc = 868;
    sync_in();
    bs = n_send;
    load_pkt(1, 40, 1'b1, 8'h40);
    plan();
    t = 0;
    while (t < 10000 && n_send < bs + 3) begin
      @(negedge clk);
      t++;
    end
    chk("third_byte_timeout", 32'(t >= 10000), 0);
    repeat (5) @(negedge clk);
    sync_in();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      sq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    m_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_grant", 32'(src_grant), 0);
    chk("midrst_send", 32'(tx_send), 0);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_ack", 32'(src_ack), 0);
    sync_in();
    rst = 1'b0;
    bs = n_send;
    load_pkt(1, 2, 1'b0, 8'h00);
    load_pkt(0, 2, 1'b0, 8'h00);
    plan();
    drain(5000, "post_reset");
    chk("post_reset_sends", 32'(n_send - bs), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
